// File: rtl/vend_pkg.sv
// Shared coin codes and scheduler state encoding for the vending front end.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_05   = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DISP  = 3'd3,
        ST_CHG   = 3'd4
    } sched_state_e;

    // Only half-yuan and one-yuan codes are forwarded to the vending FSM.
    function automatic logic coin_ok(input logic [1:0] code);
        return (code == COIN_05) || (code == COIN_10);
    endfunction

endpackage

// File: rtl/vend_rr_arb2.sv
// Two-requester round-robin arbiter; pointer moves past the winner on every grant.
module vend_rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) begin
                grant = ptr ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr <= 1'b0;
        end else if (grant != 2'b00) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/vend_coin_sched.sv
// Coin slot scheduler: arbitrates two slots, feeds one coin per transaction to the
// vending FSM, then sequences dispenser and change-hopper handshakes.
module vend_coin_sched #(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s0_valid,
    input  logic [1:0]       s0_coin,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [1:0]       s1_coin,
    output logic             s1_ready,
    output logic [1:0]       coin,
    input  logic             sell,
    input  logic [1:0]       change,
    output logic             disp_req,
    input  logic             disp_ack,
    output logic             chg_req,
    input  logic             chg_ack,
    output logic             coin_err,
    output logic             fault,
    output logic [CNT_W-1:0] sale_cnt
);
    import vend_pkg::*;

    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

    sched_state_e     state, state_nxt;
    logic [1:0]       code_q, code_nxt;
    logic [1:0]       coin_nxt;
    logic             chg_pend, chg_pend_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             fault_nxt, coin_err_nxt;
    logic [CNT_W-1:0] sale_cnt_nxt;
    logic             arb_en;
    logic [1:0]       grant;
    logic [1:0]       sel_code;
    logic             tmo;

    assign arb_en   = rstn && (state == ST_IDLE);
    assign s0_ready = grant[0];
    assign s1_ready = grant[1];
    assign sel_code = grant[1] ? s1_coin : s0_coin;
    assign tmo      = (timer == TMR_W'(ACK_TIMEOUT - 1));

    vend_rr_arb2 u_arb (
        .clk   (clk),
        .rstn  (rstn),
        .en    (arb_en),
        .valid ({s1_valid, s0_valid}),
        .grant (grant)
    );

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            code_q   <= COIN_NONE;
            coin     <= COIN_NONE;
            chg_pend <= 1'b0;
            timer    <= '0;
            fault    <= 1'b0;
            coin_err <= 1'b0;
            sale_cnt <= '0;
            disp_req <= 1'b0;
            chg_req  <= 1'b0;
        end else begin
            state    <= state_nxt;
            code_q   <= code_nxt;
            coin     <= coin_nxt;
            chg_pend <= chg_pend_nxt;
            timer    <= timer_nxt;
            fault    <= fault_nxt;
            coin_err <= coin_err_nxt;
            sale_cnt <= sale_cnt_nxt;
            disp_req <= (state_nxt == ST_DISP);
            chg_req  <= (state_nxt == ST_CHG);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        code_nxt     = code_q;
        chg_pend_nxt = chg_pend;
        timer_nxt    = timer;
        fault_nxt    = fault;
        coin_err_nxt = 1'b0;
        sale_cnt_nxt = sale_cnt;
        coin_nxt     = COIN_NONE;

        case (state)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    code_nxt = sel_code;
                    if (coin_ok(sel_code)) begin
                        state_nxt = ST_ISSUE;
                    end else begin
                        coin_err_nxt = 1'b1;
                    end
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (sell) begin
                    sale_cnt_nxt = sale_cnt + CNT_W'(1);
                    chg_pend_nxt = (change != 2'b00);
                    timer_nxt    = '0;
                    state_nxt    = ST_DISP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DISP: begin
                if (disp_ack || tmo) begin
                    fault_nxt = fault | ~disp_ack;
                    timer_nxt = '0;
                    state_nxt = chg_pend ? ST_CHG : ST_IDLE;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            ST_CHG: begin
                if (chg_ack || tmo) begin
                    fault_nxt = fault | ~chg_ack;
                    timer_nxt = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (state_nxt == ST_ISSUE) begin
            coin_nxt = code_nxt;
        end
    end

endmodule

// File: tb/tb_vend_coin_sched.sv
// Self-checking bench for vend_coin_sched: directed vector table, hand sequences,
// and random traffic checked against a transaction-level model with a vending FSM stand-in.
module tb_vend_coin_sched;

    localparam int unsigned TO   = 15;
    localparam int unsigned CW   = 8;

    logic          clk;
    logic          rstn;
    logic          s0_valid, s1_valid;
    logic [1:0]    s0_coin, s1_coin;
    logic          s0_ready, s1_ready;
    logic [1:0]    coin;
    logic          sell;
    logic [1:0]    change;
    logic          disp_req, disp_ack, chg_req, chg_ack;
    logic          coin_err, fault;
    logic [CW-1:0] sale_cnt;

    vend_coin_sched #(.ACK_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s0_valid (s0_valid),
        .s0_coin  (s0_coin),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_coin  (s1_coin),
        .s1_ready (s1_ready),
        .coin     (coin),
        .sell     (sell),
        .change   (change),
        .disp_req (disp_req),
        .disp_ack (disp_ack),
        .chg_req  (chg_req),
        .chg_ack  (chg_ack),
        .coin_err (coin_err),
        .fault    (fault),
        .sale_cnt (sale_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    logic rst_drv;

    // Reference model: transaction phases of the scheduler.
    bit          m_free, m_sample, m_disp, m_chg, m_pend, m_ptr, m_err, m_fault;
    logic [1:0]  m_coin;
    int          m_reqn;
    logic [CW-1:0] m_cnt;
    // Vending FSM stand-in: accumulates half-yuan units, sells at 2 yuan.
    int          v_total;
    bit          v_sell;
    logic [1:0]  v_chg;

    typedef struct {
        logic v0; logic [1:0] c0; logic v1; logic [1:0] c1; logic da;
        logic r0; logic r1; logic [1:0] coin; logic dreq;
    } vec_t;
    vec_t tbl[14];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endfunction

    function automatic void model_reset();
        m_free = 1; m_sample = 0; m_disp = 0; m_chg = 0; m_pend = 0;
        m_ptr = 0; m_err = 0; m_fault = 0; m_coin = 2'b00; m_reqn = 0; m_cnt = '0;
        v_total = 0; v_sell = 0; v_chg = 2'b00;
    endfunction

    function automatic int m_grant();
        if (s0_valid && s1_valid) return m_ptr ? 1 : 0;
        if (s0_valid) return 0;
        if (s1_valid) return 1;
        return -1;
    endfunction

    function automatic void model_edge();
        int g;
        logic [1:0] code;
        if (!rst_drv) begin
            model_reset();
            return;
        end
        v_sell = 0; v_chg = 2'b00;
        if (m_coin == 2'b01) v_total += 1;
        else if (m_coin == 2'b10) v_total += 2;
        if (v_total >= 4) begin
            v_sell = 1; v_chg = 2'(v_total - 4); v_total = 0;
        end
        m_err = 0;
        if (m_free) begin
            g = m_grant();
            if (g >= 0) begin
                code = (g == 1) ? s1_coin : s0_coin;
                m_ptr = (g == 0);
                if (code == 2'b01 || code == 2'b10) begin
                    m_free = 0; m_coin = code;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_coin != 2'b00) begin
            m_coin = 2'b00; m_sample = 1;
        end else if (m_sample) begin
            m_sample = 0;
            if (sell) begin
                m_cnt = m_cnt + 1'b1; m_disp = 1; m_pend = (change != 2'b00); m_reqn = 0;
            end else begin
                m_free = 1;
            end
        end else if (m_disp) begin
            m_reqn++;
            if (disp_ack || m_reqn == TO) begin
                if (!disp_ack) m_fault = 1;
                m_disp = 0;
                if (m_pend) begin m_chg = 1; m_reqn = 0; end
                else m_free = 1;
            end
        end else if (m_chg) begin
            m_reqn++;
            if (chg_ack || m_reqn == TO) begin
                if (!chg_ack) m_fault = 1;
                m_chg = 0; m_free = 1;
            end
        end
    endfunction

    // One clock: drive at negedge, compare mid-cycle, advance the model.
    task automatic cycle(input logic v0, input logic [1:0] c0, input logic v1,
                         input logic [1:0] c1, input logic da, input logic ca);
        int g;
        @(negedge clk);
        rstn = rst_drv; s0_valid = v0; s0_coin = c0; s1_valid = v1; s1_coin = c1;
        disp_ack = da; chg_ack = ca; sell = v_sell; change = v_chg;
        #1;
        g = m_grant();
        chk("s0_ready", s0_ready, rst_drv && m_free && g == 0);
        chk("s1_ready", s1_ready, rst_drv && m_free && g == 1);
        chk("coin", coin, m_coin);
        chk("disp_req", disp_req, m_disp);
        chk("chg_req", chg_req, m_chg);
        chk("coin_err", coin_err, m_err);
        chk("fault", fault, m_fault);
        chk("sale_cnt", sale_cnt, m_cnt);
        model_edge();
    endtask

    task automatic idle(input logic da, input logic ca);
        cycle(1'b0, 2'b00, 1'b0, 2'b00, da, ca);
    endtask

    task automatic do_reset();
        rst_drv = 1'b0;
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        rst_drv = 1'b1;
    endtask

    // Grant cycle, ISSUE cycle, WAIT cycle.
    task automatic coin_txn(input bit slot, input logic [1:0] code);
        cycle(slot == 1'b0, code, slot == 1'b1, code, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; rst_drv = 1'b0;
        s0_valid = 0; s1_valid = 0; s0_coin = 0; s1_coin = 0;
        disp_ack = 0; chg_ack = 0; sell = 0; change = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state
        idle(1'b0, 1'b0);
        chk("rst_coin", coin, 0); chk("rst_disp", disp_req, 0); chk("rst_chg", chg_req, 0);
        chk("rst_err", coin_err, 0); chk("rst_fault", fault, 0); chk("rst_cnt", sale_cnt, 0);
        rst_drv = 1'b1;

        // Both slots hold 01: grants alternate s0,s1,s0,s1; fourth coin sells; dispense acked.
        for (int i = 0; i < 13; i++) tbl[i] = '{1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[13] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[0].r0 = 1; tbl[3].r1 = 1; tbl[6].r0 = 1; tbl[9].r1 = 1;
        tbl[1].coin = 2'b01; tbl[4].coin = 2'b01; tbl[7].coin = 2'b01; tbl[10].coin = 2'b01;
        tbl[12].dreq = 1;
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].v0, tbl[i].c0, tbl[i].v1, tbl[i].c1, tbl[i].da, 1'b0);
            chk($sformatf("tbl%0d_r0", i), s0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_r1", i), s1_ready, tbl[i].r1);
            chk($sformatf("tbl%0d_coin", i), coin, tbl[i].coin);
            chk($sformatf("tbl%0d_dreq", i), disp_req, tbl[i].dreq);
            chk($sformatf("tbl%0d_creq", i), chg_req, 0);
        end
        chk("tbl_sale_cnt", sale_cnt, 1);

        // Invalid code 11 on s1: accepted, coin_err pulse, no coin issued.
        cycle(1'b0, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("bad_s1_ready", s1_ready, 1);
        idle(1'b0, 1'b0);
        chk("bad_err_pulse", coin_err, 1); chk("bad_coin", coin, 0);
        cycle(1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 1'b0);
        chk("bad_err_clear", coin_err, 0); chk("bad_ptr_s0", s0_ready, 1);
        do_reset();

        // 1.0 + 0.5 + 1.0: sale with 0.5 change, dispense then change hopper.
        coin_txn(1'b0, 2'b10); coin_txn(1'b1, 2'b01); coin_txn(1'b0, 2'b10);
        idle(1'b1, 1'b0);
        chk("chg_disp_req", disp_req, 1); chk("chg_disp_nochg", chg_req, 0);
        idle(1'b0, 1'b1);
        chk("chg_req", chg_req, 1); chk("chg_disp_off", disp_req, 0);
        cycle(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("chg_done_req", chg_req, 0); chk("chg_done_ready", s0_ready, 1);
        chk("chg_done_cnt", sale_cnt, 1); chk("chg_done_fault", fault, 0);
        do_reset();

        // Dispense ack never arrives: request held ACK_TIMEOUT cycles, fault sticky.
        coin_txn(1'b0, 2'b10); coin_txn(1'b0, 2'b10);
        for (int i = 0; i < int'(TO); i++) begin
            idle(1'b0, 1'b0);
            chk($sformatf("tmo_hold%0d", i), disp_req, 1);
        end
        idle(1'b0, 1'b0);
        chk("tmo_drop", disp_req, 0); chk("tmo_fault", fault, 1); chk("tmo_nochg", chg_req, 0);
        repeat (5) idle(1'b0, 1'b0);
        chk("tmo_sticky", fault, 1);

        // Reset while dispensing.
        coin_txn(1'b0, 2'b10); coin_txn(1'b0, 2'b10);
        idle(1'b0, 1'b0);
        chk("rdisp_req", disp_req, 1); chk("rdisp_cnt", sale_cnt, 2);
        rst_drv = 1'b0;
        idle(1'b0, 1'b0);
        rst_drv = 1'b1;
        cycle(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("rdisp_drop", disp_req, 0); chk("rdisp_cnt0", sale_cnt, 0);
        chk("rdisp_fault0", fault, 0); chk("rdisp_ready", s0_ready, 1);
        do_reset();

        // sale_cnt wraps modulo 2^CW.
        for (int i = 0; i < (1 << CW); i++) begin
            coin_txn(1'b0, 2'b10); coin_txn(1'b0, 2'b10);
            idle(1'b1, 1'b0);
            if (i == (1 << CW) - 2) chk("wrap_max", sale_cnt, (1 << CW) - 1);
        end
        idle(1'b0, 1'b0);
        chk("wrap_zero", sale_cnt, 0);
        do_reset();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_drv = ($urandom_range(0, 299) != 0);
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 9) < 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
